// File: rtl/mult_share_sched_pkg.sv
// Shared types and parameter floors for the time-shared multiplier scheduler.
package mult_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  localparam int MIN_NREQ   = 2;
  localparam int MIN_SETTLE = 1;

  function automatic bit params_ok(input int nreq, input int settle);
    return (nreq >= MIN_NREQ) && (settle >= MIN_SETTLE);
  endfunction

endpackage

// File: rtl/mult_share_sched_if.sv
// Requester, response and shared-multiplier signals of mult_share_sched.
// Handshakes: a transfer happens on a rising edge where valid and ready are both high;
// the source holds valid and payload stable until then; ready may depend on valid.
interface mult_share_sched_if #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4,
  parameter int IDW   = $clog2(NREQ)
) ();
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [WIDTH-1:0]      mul_a;
  logic [WIDTH-1:0]      mul_b;
  logic [2*WIDTH-1:0]    mul_p;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [2*WIDTH-1:0]    rsp_p;

  modport slave (
    input  req_valid, req_a, req_b, mul_p, rsp_ready,
    output req_ready, mul_a, mul_b, rsp_valid, rsp_id, rsp_p
  );

  modport master (
    output req_valid, req_a, req_b, mul_p, rsp_ready,
    input  req_ready, mul_a, mul_b, rsp_valid, rsp_id, rsp_p
  );
endinterface

// File: rtl/mult_share_sched_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr, cyclically.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  win,
  output logic            any_req
);

  always_comb begin
    int idx;
    grant   = '0;
    win     = '0;
    any_req = 1'b0;
    idx     = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = (int'(ptr) + i) % NREQ;
      if (!any_req && req[idx]) begin
        any_req    = 1'b1;
        grant[idx] = 1'b1;
        win        = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/mult_share_sched.sv
// Round-robin scheduler sharing one external combinational multiplier among NREQ requesters.
// Operands are registered, held for SETTLE cycles on the multiplier, then P is captured.
module mult_share_sched
  import mult_sched_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int NREQ   = 4,
  parameter int SETTLE = 2,
  parameter int IDW    = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  mult_share_sched_if.slave bus,
  output logic              busy,
  output state_e            state_dbg
);

  // Out-of-range SETTLE falls back to the shortest legal window.
  localparam int SETTLE_C = params_ok(NREQ, SETTLE) ? SETTLE : MIN_SETTLE;
  localparam int CW       = (SETTLE_C > 1) ? $clog2(SETTLE_C) : 1;
  localparam logic [CW-1:0]  CNT_LOAD = CW'(SETTLE_C - 1);
  localparam logic [IDW-1:0] LAST_ID  = IDW'(NREQ - 1);

  state_e               state_q, state_d;
  logic [IDW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]       cur_id_q, cur_id_d;
  logic [WIDTH-1:0]     op_a_q, op_a_d;
  logic [WIDTH-1:0]     op_b_q, op_b_d;
  logic [CW-1:0]        settle_cnt_q, settle_cnt_d;
  logic [2*WIDTH-1:0]   rsp_p_q, rsp_p_d;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ-1:0]      grant;
  logic [IDW-1:0]       win;
  logic                 any_req;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req     (bus.req_valid),
    .ptr     (rr_ptr_q),
    .grant   (grant),
    .win     (win),
    .any_req (any_req)
  );

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    cur_id_d     = cur_id_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    settle_cnt_d = settle_cnt_q;
    rsp_p_d      = rsp_p_q;
    req_ready    = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          req_ready    = grant;
          op_a_d       = bus.req_a[int'(win)*WIDTH +: WIDTH];
          op_b_d       = bus.req_b[int'(win)*WIDTH +: WIDTH];
          cur_id_d     = win;
          settle_cnt_d = CNT_LOAD;
          state_d      = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (settle_cnt_q == '0) begin
          rsp_p_d = bus.mul_p;
          state_d = ST_RESP;
        end else begin
          settle_cnt_d = settle_cnt_q - 1'b1;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          rr_ptr_d = (cur_id_q == LAST_ID) ? '0 : cur_id_q + 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Grants must vanish as soon as reset is asserted, not at the next edge.
    if (!rst_n) req_ready = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      rr_ptr_q     <= '0;
      cur_id_q     <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      settle_cnt_q <= '0;
      rsp_p_q      <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      cur_id_q     <= cur_id_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      settle_cnt_q <= settle_cnt_d;
      rsp_p_q      <= rsp_p_d;
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.mul_a     = op_a_q;
  assign bus.mul_b     = op_b_q;
  assign bus.rsp_valid = (state_q == ST_RESP);
  assign bus.rsp_id    = cur_id_q;
  assign bus.rsp_p     = rsp_p_q;
  assign busy          = (state_q != ST_IDLE);
  assign state_dbg     = state_q;

endmodule

// File: doc/mult_share_sched.md
# mult_share_sched

Round-robin scheduler that time-shares one combinational multiplier instance among NREQ requesters. Accepts operand pairs over per-requester valid/ready, drives the shared multiplier's A/B inputs from registered operands, holds them for a fixed settle window, captures P, and returns the product with the requester's index. The multiplier stays outside this block, so any generated multiplier netlist (`multiplier`, ports A/B/P) plugs in unchanged.

## Interface
- WIDTH, 8: operand width; product is 2*WIDTH.
- NREQ, 4: number of requesters; must be ≥2.
- SETTLE, 2: cycles operands are held on the multiplier before P is sampled; must be ≥1.
- IDW, $clog2(NREQ): requester index width.

- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester operand valid.
- req_ready  out  NREQ  per-requester accept; at most one bit high.
- req_a  in  NREQ*WIDTH  packed A operands; slice i belongs to requester i.
- req_b  in  NREQ*WIDTH  packed B operands.
- mul_a  out  WIDTH  to shared multiplier A.
- mul_b  out  WIDTH  to shared multiplier B.
- mul_p  in  2*WIDTH  from shared multiplier P.
- rsp_valid  out  1  product valid.
- rsp_ready  in  1  consumer accepts product.
- rsp_id  out  IDW  index of requester owning rsp_p.
- rsp_p  out  2*WIDTH  captured product.
- busy  out  1  high whenever state ≠ IDLE.

## Operation
- States: IDLE, SETTLE, RESP.
- IDLE: if any req_valid, the arbiter picks the first set bit at or after rr_ptr (cyclic). req_ready[win]=1 combinationally in this cycle; at the edge, latch the operands into op_a/op_b, latch win into cur_id, load settle_cnt=SETTLE-1, go to SETTLE. No req_valid: stay.
- SETTLE: mul_a=op_a, mul_b=op_b. If settle_cnt=0: capture mul_p into rsp_p and go to RESP; otherwise decrement.
- RESP: rsp_valid=1, rsp_id=cur_id, rsp_p stable. On rsp_ready: rr_ptr=(cur_id+1) mod NREQ (wraps NREQ-1→0), go to IDLE. Without rsp_ready: hold all outputs.
- mul_a/mul_b always reflect op_a/op_b (also in IDLE/RESP); they only change at an accept edge.
- req_ready is 0 in SETTLE and RESP, so no new accept can happen while an op is in flight.
- Requesters must hold req_valid and operands until their req_ready; dropping req_valid before grant is legal and simply removes the requester from arbitration.
- Product is unsigned, full 2*WIDTH; no truncation, no saturation.
- A requester starves for at most NREQ-1 ops.

## Timing
- Reset (async, immediate): state=IDLE, rr_ptr=0, cur_id=0, op_a=op_b=0, settle_cnt=0, rsp_p=0, rsp_valid=0, req_ready=0, busy=0, mul_a=mul_b=0.
- Accept at edge T0: SETTLE during cycles T0+1..T0+SETTLE; rsp_valid high from T0+SETTLE+1.
- Latency accept→rsp_valid = SETTLE+1 cycles; minimum op period = SETTLE+2 cycles (rsp_ready tied high).
- rsp_ready seen in the same cycle rsp_valid rises completes the transfer in that cycle.
- The IDLE cycle after RESP arbitrates with the updated rr_ptr; there is no back-to-back accept without an IDLE cycle.
- Reset asserted mid-SETTLE or mid-RESP: the op is dropped, no response is produced, and rr_ptr returns to 0.

## Structure
- Package mult_sched_pkg: state enum (IDLE, SETTLE, RESP) and localparam checks (NREQ≥2, SETTLE≥1).
- Sub-module rr_arbiter (NREQ): inputs req vector and ptr; outputs a one-hot grant, win index, and any_req. It is purely combinational.
- The top holds the FSM, the operand and result registers, and the settle counter.

## Test plan
- Single request: WIDTH=8, SETTLE=2, requester 1 sends A=3, B=3 → req_ready[1] for 1 cycle; rsp_valid 3 cycles later with rsp_id=1, rsp_p=9.
- Contention: all 4 valid from reset, operands (1,3),(3,3),(3,2),(2,3), rsp_ready=1 → responses in order id 0,1,2,3 with products 3,9,6,6; rr_ptr wraps to 0.
- Fairness after wrap: rr_ptr=3, requesters 0 and 3 valid → id 3 is served first, then id 0.
- Backpressure: rsp_ready=0 for 5 cycles in RESP → rsp_valid, rsp_p, rsp_id stay stable; req_ready stays 0 for all requesters; the op completes on the first rsp_ready.
- Boundary values: A=255, B=255 → rsp_p=65025; A=0, B=200 → rsp_p=0.
- Reset mid-op: rst_n low during SETTLE → all outputs drop to reset values in the same cycle, with no response after release; the next request is arbitrated from rr_ptr=0.
